// File: rtl/ebi_read_responder.sv
// Purpose : EBI read-side responder; latches address on ALE and serves RE reads from the bank mux.
// Latency : rd_req 1 cycle after the synchronized RE fall is seen; data driven 1 cycle after rd_valid.
// Backpr. : none toward the MCU; waits up to TIMEOUT cycles for rd_valid, then drives 16'hDEAD.
//
// Ports:
//   clk, reset                  pixel clock, async active-high reset
//   ebi_ad_in/ale/re_n          raw EBI pad inputs (synchronized internally)
//   bank_select                 bank code of the access (synchronized internally)
//   ebi_ad_out, ebi_ad_oe       read data and pad output enable
//   rd_req, rd_bank, rd_addr    single-cycle read request toward the bank mux
//   rd_data, rd_valid           bank mux response
//   busy, err_timeout           status; err_timeout is sticky until reset
module ebi_read_responder #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 15,
  parameter int NUM_BANKS   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ebi_ad_in,
  input  logic              ebi_ale,
  input  logic              ebi_re_n,
  input  logic [2:0]        bank_select,
  output logic [DATA_W-1:0] ebi_ad_out,
  output logic              ebi_ad_oe,
  output logic              rd_req,
  output logic [2:0]        rd_bank,
  output logic [DATA_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic              busy,
  output logic              err_timeout
);

  localparam int                CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  // The timeout fires in the WAIT cycle whose increment would make the count reach TIMEOUT.
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]        NUM_BANKS_L = 4'(NUM_BANKS);
  localparam logic [DATA_W-1:0] DEAD_WORD   = DATA_W'(16'hDEAD);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRIVE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]      ad_sync   [SYNC_STAGES];
  logic [2:0]             bank_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ale_sync;
  logic [SYNC_STAGES-1:0] re_sync;
  logic                   ale_d;
  logic                   re_d;
  logic                   ale_s;
  logic                   re_s;
  logic                   ale_fall;
  logic                   ale_rise;
  logic                   re_fall;
  logic                   re_rise;
  logic                   bank_valid;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   load_out;
  logic [DATA_W-1:0]      out_nxt;
  logic                   set_err;

  // Input synchronizers, reset to the inactive bus levels, plus one extra
  // delay on ALE/RE for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ad_sync[i]   <= '0;
        bank_sync[i] <= '0;
        ale_sync[i]  <= 1'b0;
        re_sync[i]   <= 1'b1;
      end
      ale_d <= 1'b0;
      re_d  <= 1'b1;
    end else begin
      ad_sync[0]   <= ebi_ad_in;
      bank_sync[0] <= bank_select;
      ale_sync[0]  <= ebi_ale;
      re_sync[0]   <= ebi_re_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ad_sync[i]   <= ad_sync[i-1];
        bank_sync[i] <= bank_sync[i-1];
        ale_sync[i]  <= ale_sync[i-1];
        re_sync[i]   <= re_sync[i-1];
      end
      ale_d <= ale_s;
      re_d  <= re_s;
    end
  end

  assign ale_s    = ale_sync[SYNC_STAGES-1];
  assign re_s     = re_sync[SYNC_STAGES-1];
  assign ale_fall = ale_d & ~ale_s;
  assign ale_rise = ~ale_d & ale_s;
  assign re_fall  = re_d & ~re_s;   // strobe asserted
  assign re_rise  = ~re_d & re_s;   // strobe released

  // Address/bank capture is taken from the same synchronized sample as the
  // ALE edge, in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      rd_bank <= '0;
    end else if (ale_fall) begin
      rd_addr <= ad_sync[SYNC_STAGES-1];
      rd_bank <= bank_sync[SYNC_STAGES-1];
    end
  end

  assign bank_valid = ({1'b0, rd_bank} < NUM_BANKS_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    out_nxt   = '0;
    set_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (re_fall) begin
          if (bank_valid) begin
            state_nxt = S_REQ;
          end else begin
            // Unmapped bank: answer with zero without touching the bank mux.
            state_nxt = S_DRIVE;
            load_out  = 1'b1;
          end
        end
      end
      S_REQ: state_nxt = S_WAIT;
      S_WAIT: begin
        // An RE release beats a same-cycle response: the MCU has gone away.
        if (re_rise) begin
          state_nxt = S_IDLE;
        end else if (rd_valid) begin
          state_nxt = S_DRIVE;
          load_out  = 1'b1;
          out_nxt   = rd_data;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = S_DRIVE;
          load_out  = 1'b1;
          out_nxt   = DEAD_WORD;
          set_err   = 1'b1;
        end
      end
      S_DRIVE: begin
        // Any ALE activity while driving means the MCU started a new cycle
        // on top of ours; drop the bus immediately.
        if (re_rise || ale_rise || ale_fall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Wait counter: cleared in REQ, counts in WAIT, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_REQ) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT && wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ebi_ad_out  <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (load_out) ebi_ad_out  <= out_nxt;
      if (set_err)  err_timeout <= 1'b1;
    end
  end

  // Decoded straight from the state register so reset drops the pad driver
  // without waiting for a clock edge.
  assign ebi_ad_oe = (state == S_DRIVE);
  assign rd_req    = (state == S_REQ);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ebi_read_responder.sv
`timescale 1ns/1ps
module tb_ebi_read_responder;

    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 15;
    localparam int NUM_BANKS   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] ebi_ad_in;
    logic              ebi_ale;
    logic              ebi_re_n;
    logic [2:0]        bank_select;
    logic [DATA_W-1:0] ebi_ad_out;
    logic              ebi_ad_oe;
    logic              rd_req;
    logic [2:0]        rd_bank;
    logic [DATA_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              err_timeout;

    always #5 clk = ~clk;

    ebi_read_responder #(
        .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .NUM_BANKS(NUM_BANKS)
    ) dut (
        .clk(clk), .reset(reset),
        .ebi_ad_in(ebi_ad_in), .ebi_ale(ebi_ale), .ebi_re_n(ebi_re_n), .bank_select(bank_select),
        .ebi_ad_out(ebi_ad_out), .ebi_ad_oe(ebi_ad_oe),
        .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard: resp_q feeds the bank-mux model, exp_q holds the word the
    // pad must show, req_log records every observed request as {bank, addr}.
    logic [DATA_W-1:0]   resp_q  [$];
    logic [DATA_W-1:0]   exp_q   [$];
    logic [DATA_W+2:0]   req_log [$];
    int                  resp_lat = 1;
    logic [DATA_W-1:0]   rsp;

    always @(negedge clk) begin
        if (rd_req === 1'b1) req_log.push_back({rd_bank, rd_addr});
    end

    // Bank-mux model: answers a request resp_lat cycles after the rd_req cycle
    // (0 = during the rd_req cycle itself), holding rd_valid for one cycle.
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_req === 1'b1 && resp_q.size() > 0) begin
                rsp = resp_q.pop_front();
                if (resp_lat > 0) begin
                    repeat (resp_lat) @(posedge clk);
                    #1;
                end
                rd_valid = 1'b1;
                rd_data  = rsp;
                @(posedge clk);
                #1;
                rd_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ale_pulse(input logic [DATA_W-1:0] a, input logic [2:0] b);
        ebi_ad_in   = a;
        bank_select = b;
        ebi_ale     = 1'b1;
        cyc(3);
        ebi_ale     = 1'b0;
        cyc(4);
        ebi_ad_in   = 16'hFFFF;  // bus moves on; the latched address must not
    endtask

    // Negedge index (1-based, from the call) at which ebi_ad_oe is first 1; -1 if never.
    task automatic wait_oe(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (ebi_ad_oe === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Negedge index at which ebi_ad_oe is first 0; -1 if never.
    task automatic wait_release(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (ebi_ad_oe === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    // Input changes land at posedge+1, so the synchronized edge is detected in
    // the cycle of negedge index SYNC_STAGES+1 (cycle T). rd_req is at T+1.
    localparam int IDX_T = SYNC_STAGES + 1;

    task automatic test_reset;
        reset = 1'b1; ebi_ad_in = '0; ebi_ale = 1'b0; ebi_re_n = 1'b1; bank_select = '0;
        cyc(3);
        total++;
        if ({ebi_ad_oe, rd_req, busy, err_timeout} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000", {ebi_ad_oe, rd_req, busy, err_timeout});
        end
        total++;
        if (ebi_ad_out !== 16'h0000) begin
            bad++;
            $display("FAIL reset_ad_out got=%h exp=0000", ebi_ad_out);
        end
        total++;
        if ({rd_bank, rd_addr} !== 19'd0) begin
            bad++;
            $display("FAIL reset_addr got=%h exp=0", {rd_bank, rd_addr});
        end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_basic;
        int req_at, oe_at, n, req_n;
        logic [DATA_W-1:0] e;
        resp_lat = 1;
        ale_pulse(16'h0012, 3'd3);
        req_log.delete();
        resp_q.push_back(16'hABCD);
        exp_q.push_back(16'hABCD);
        ebi_re_n = 1'b0;
        req_at = -1; oe_at = -1; req_n = 0;
        for (int i = 1; i <= 40 && oe_at < 0; i++) begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                req_n++;
                if (req_at < 0) req_at = i;
            end
            if (ebi_ad_oe === 1'b1) oe_at = i;
        end
        total++;
        if (req_at != IDX_T + 1) begin
            bad++;
            $display("FAIL basic_req_time got=%0d exp=%0d", req_at, IDX_T + 1);
        end
        total++;
        if (req_n != 1) begin
            bad++;
            $display("FAIL basic_req_width got=%0d exp=1", req_n);
        end
        // rd_valid in T+2, data on the pad at T+3.
        total++;
        if (oe_at != IDX_T + 3) begin
            bad++;
            $display("FAIL basic_oe_time got=%0d exp=%0d", oe_at, IDX_T + 3);
        end
        e = exp_q.pop_front();
        total++;
        if (ebi_ad_out !== e) begin
            bad++;
            $display("FAIL basic_data got=%h exp=%h", ebi_ad_out, e);
        end
        cyc(3);
        total++;
        if (ebi_ad_oe !== 1'b1 || ebi_ad_out !== e) begin
            bad++;
            $display("FAIL basic_hold got=%b/%h exp=1/%h", ebi_ad_oe, ebi_ad_out, e);
        end
        ebi_re_n = 1'b1;
        wait_release(12, n);
        total++;
        if (n != SYNC_STAGES + 2) begin
            bad++;
            $display("FAIL basic_release_latency got=%0d exp=%0d", n, SYNC_STAGES + 2);
        end
        cyc(4);
        total++;
        if (req_log.size() != 1 || req_log[0] !== {3'd3, 16'h0012}) begin
            bad++;
            $display("FAIL basic_req_fields got=%0d/%h exp=1/%h", req_log.size(),
                     (req_log.size() > 0) ? req_log[0] : 19'd0, {3'd3, 16'h0012});
        end
    endtask

    task automatic test_invalid_bank;
        int n;
        logic [DATA_W-1:0] e;
        ale_pulse(16'h0040, 3'd6);
        req_log.delete();
        exp_q.push_back(16'h0000);
        ebi_re_n = 1'b0;
        wait_oe(40, n);
        total++;
        if (n != IDX_T + 1) begin
            bad++;
            $display("FAIL invalid_oe_time got=%0d exp=%0d", n, IDX_T + 1);
        end
        e = exp_q.pop_front();
        total++;
        if (ebi_ad_out !== e) begin
            bad++;
            $display("FAIL invalid_data got=%h exp=%h", ebi_ad_out, e);
        end
        cyc(2);
        ebi_re_n = 1'b1;
        cyc(6);
        total++;
        if (req_log.size() != 0) begin
            bad++;
            $display("FAIL invalid_no_req got=%0d exp=0", req_log.size());
        end
        total++;
        if ({ebi_ad_oe, busy, err_timeout} !== 3'b000) begin
            bad++;
            $display("FAIL invalid_after got=%b exp=000", {ebi_ad_oe, busy, err_timeout});
        end
    endtask

    task automatic test_timeout(input int lat, input logic [DATA_W-1:0] early);
        int n;
        logic [DATA_W-1:0] e;
        resp_lat = lat;
        ale_pulse(16'h0100, 3'd1);
        if (lat == 0) resp_q.push_back(early);  // lands in the rd_req cycle, must be ignored
        exp_q.push_back(16'hDEAD);
        ebi_re_n = 1'b0;
        wait_oe(80, n);
        // rd_req at T+1, DEAD on the pad at T+2+TIMEOUT.
        total++;
        if (n != IDX_T + 2 + TIMEOUT) begin
            bad++;
            $display("FAIL timeout_oe_time lat=%0d got=%0d exp=%0d", lat, n, IDX_T + 2 + TIMEOUT);
        end
        e = exp_q.pop_front();
        total++;
        if (ebi_ad_out !== e) begin
            bad++;
            $display("FAIL timeout_data lat=%0d got=%h exp=%h", lat, ebi_ad_out, e);
        end
        total++;
        if (err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_err got=%b exp=1", err_timeout);
        end
        cyc(2);
        ebi_re_n = 1'b1;
        cyc(6);
        total++;
        if ({busy, err_timeout} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_sticky got=%b exp=01", {busy, err_timeout});
        end
        resp_lat = 1;
    endtask

    task automatic test_abort;
        int seen_req;
        logic oe_seen;
        resp_lat = 5;  // RE release seen at T+3, response at T+6
        ale_pulse(16'h0200, 3'd2);
        req_log.delete();
        resp_q.push_back(16'h7777);
        ebi_re_n = 1'b0;
        seen_req = 0;
        for (int i = 0; i < 20 && seen_req == 0; i++) begin
            @(negedge clk);
            if (rd_req === 1'b1) seen_req = 1;
        end
        total++;
        if (seen_req != 1) begin
            bad++;
            $display("FAIL abort_req got=%0d exp=1", seen_req);
        end
        ebi_re_n = 1'b1;
        oe_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ebi_ad_oe !== 1'b0) oe_seen = 1'b1;
        end
        total++;
        if (oe_seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_drive got=%b exp=0", oe_seen);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle got=%b exp=0", busy);
        end
        resp_lat = 1;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [DATA_W-1:0] d, e;
        resp_lat = 1;
        ale_pulse(16'h0033, 3'd0);
        req_log.delete();
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 16'h1111 : 16'h2222;
            resp_q.push_back(d);
            exp_q.push_back(d);
            ebi_re_n = 1'b0;
            wait_oe(40, n);
            total++;
            if (n != IDX_T + 3) begin
                bad++;
                $display("FAIL b2b_oe_time k=%0d got=%0d exp=%0d", k, n, IDX_T + 3);
            end
            e = exp_q.pop_front();
            total++;
            if (ebi_ad_out !== e) begin
                bad++;
                $display("FAIL b2b_data k=%0d got=%h exp=%h", k, ebi_ad_out, e);
            end
            cyc(2);
            ebi_re_n = 1'b1;
            cyc(6);
            total++;
            if (ebi_ad_oe !== 1'b0) begin
                bad++;
                $display("FAIL b2b_release k=%0d got=%b exp=0", k, ebi_ad_oe);
            end
        end
        total++;
        if (req_log.size() != 2 || req_log[0] !== {3'd0, 16'h0033} || req_log[1] !== {3'd0, 16'h0033}) begin
            bad++;
            $display("FAIL b2b_reqs got=%0d exp=2 same addr %h", req_log.size(), {3'd0, 16'h0033});
        end
    endtask

    task automatic test_ale_violation;
        int n;
        resp_lat = 1;
        ale_pulse(16'h0044, 3'd4);
        resp_q.push_back(16'h4444);
        ebi_re_n = 1'b0;
        wait_oe(40, n);
        total++;
        if (ebi_ad_out !== 16'h4444 || n < 0) begin
            bad++;
            $display("FAIL viol_data got=%h exp=4444", ebi_ad_out);
        end
        cyc(1);
        ebi_ad_in = 16'h0055;
        ebi_ale   = 1'b1;
        wait_release(12, n);
        total++;
        if (n != SYNC_STAGES + 2) begin
            bad++;
            $display("FAIL viol_release got=%0d exp=%0d", n, SYNC_STAGES + 2);
        end
        cyc(1);
        ebi_ale = 1'b0;
        cyc(5);
        total++;
        if (rd_addr !== 16'h0055 || busy !== 1'b0) begin
            bad++;
            $display("FAIL viol_capture got=%h/%b exp=0055/0", rd_addr, busy);
        end
        ebi_re_n = 1'b1;
        cyc(4);
    endtask

    task automatic test_reset_mid_drive;
        int n;
        resp_lat = 1;
        ale_pulse(16'h0066, 3'd3);
        resp_q.push_back(16'h6666);
        ebi_re_n = 1'b0;
        wait_oe(40, n);
        total++;
        if (n < 0 || ebi_ad_out !== 16'h6666) begin
            bad++;
            $display("FAIL rstdrv_setup got=%0d/%h exp=drive/6666", n, ebi_ad_out);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (ebi_ad_oe !== 1'b0) begin
            bad++;
            $display("FAIL rstdrv_async_oe got=%b exp=0", ebi_ad_oe);
        end
        total++;
        if ({rd_req, busy, err_timeout, ebi_ad_out, rd_bank, rd_addr} !== 35'd0) begin
            bad++;
            $display("FAIL rstdrv_values got=%h exp=0", {rd_req, busy, err_timeout, ebi_ad_out, rd_bank, rd_addr});
        end
        cyc(2);
        ebi_re_n = 1'b1;
        reset    = 1'b0;
        cyc(4);
        total++;
        if ({ebi_ad_oe, busy, err_timeout} !== 3'b000) begin
            bad++;
            $display("FAIL rstdrv_after got=%b exp=000", {ebi_ad_oe, busy, err_timeout});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid_bank();
        test_timeout(1, 16'h0000);
        test_timeout(0, 16'h5A5A);
        test_abort();
        test_back_to_back();
        test_ale_violation();
        test_reset_mid_drive();
        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad == 0) $display("PASS");
        else          $display("FAIL");
        $finish;
    end

endmodule
